// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryptor: forward key expansion, then one inverse round per clock.
// Optional rk10 cache enabled by defining AES_DEC_KEYCACHE_EN.

package aes_dec_pkg;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = xtime(x);
      end
      return r;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as required.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
      logic [15:0] d;
      d = {x, x} << k;
      return d[15:8];
   endfunction

endpackage

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_dec_pkg::*;
   logic [7:0] v;
   assign v = gf_inv(a);
   assign y = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_dec_pkg::*;
   logic [7:0] v;
   assign v = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
   assign y = gf_inv(v);
endmodule

module aes_decrypt #(
   parameter int unsigned ROUND = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] C,
   input  logic [127:0] K,
   output logic [127:0] P,
   output logic         valid,
   output logic         busy
);
   import aes_dec_pkg::*;

   localparam logic [3:0] LastRnd = 4'(ROUND - 1);

   typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRounds, StFinal} fsm_e;

   fsm_e         fsm_q;
   logic [127:0] st_q, key_q;
   logic [3:0]   cnt_q;

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0: return 8'h01;
         4'd1: return 8'h02;
         4'd2: return 8'h04;
         4'd3: return 8'h08;
         4'd4: return 8'h10;
         4'd5: return 8'h20;
         4'd6: return 8'h40;
         4'd7: return 8'h80;
         4'd8: return 8'h1b;
         4'd9: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Byte b of the block sits at row b%4, column b/4.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // Forward and inverse schedule share one SubWord; the inverse recovers old w3 first.
   logic [31:0] k0, k1, k2, k3, sched_w, rot_w, sub_w, temp_w;
   logic [127:0] fwd_key, inv_key;

   assign {k0, k1, k2, k3} = key_q;
   assign sched_w = (fsm_q == StKeyExp) ? k3 : (k3 ^ k2);
   assign rot_w   = {sched_w[23:0], sched_w[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .a(rot_w[8*i +: 8]),
         .y(sub_w[8*i +: 8])
      );
   end

   assign temp_w  = sub_w ^ {rcon(cnt_q), 24'h0};
   assign fwd_key = {k0 ^ temp_w, k0 ^ k1 ^ temp_w, k0 ^ k1 ^ k2 ^ temp_w,
                     k0 ^ k1 ^ k2 ^ k3 ^ temp_w};
   assign inv_key = {k0 ^ temp_w, k0 ^ k1, k1 ^ k2, k2 ^ k3};

   logic [127:0] isr, isb, ark, imc;

   assign isr = inv_shift_rows(st_q);

   for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
      aes_inv_sbox u_inv_sbox (
         .a(isr[8*i +: 8]),
         .y(isb[8*i +: 8])
      );
   end

   assign ark = isb ^ key_q;
   assign imc = {inv_mix_col(ark[127:96]), inv_mix_col(ark[95:64]),
                 inv_mix_col(ark[63:32]), inv_mix_col(ark[31:0])};

   logic hit;
`ifdef AES_DEC_KEYCACHE_EN
   logic         cache_ok_q;
   logic [127:0] cache_key_q, cache_rk_q;
   assign hit = cache_ok_q && (K == cache_key_q);
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q       <= StIdle;
         st_q        <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         P           <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
         cache_ok_q  <= 1'b0;
         cache_key_q <= '0;
         cache_rk_q  <= '0;
`endif
      end else begin
         valid <= 1'b0;
         case (fsm_q)
            StIdle: begin
               if (start) begin
                  st_q <= C;
                  busy <= 1'b1;
                  if (hit) begin
`ifdef AES_DEC_KEYCACHE_EN
                     key_q <= cache_rk_q;
`endif
                     cnt_q <= LastRnd;
                     fsm_q <= StInit;
                  end else begin
                     key_q <= K;
                     cnt_q <= '0;
                     fsm_q <= StKeyExp;
`ifdef AES_DEC_KEYCACHE_EN
                     cache_ok_q  <= 1'b0;
                     cache_key_q <= K;
`endif
                  end
               end
            end
            StKeyExp: begin
               key_q <= fwd_key;
               if (cnt_q == LastRnd) begin
                  fsm_q <= StInit;
`ifdef AES_DEC_KEYCACHE_EN
                  cache_rk_q <= fwd_key;
                  cache_ok_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StInit: begin
               st_q  <= st_q ^ key_q;
               key_q <= inv_key;
               cnt_q <= cnt_q - 4'd1;
               fsm_q <= StRounds;
            end
            StRounds: begin
               st_q  <= imc;
               key_q <= inv_key;
               if (cnt_q == 4'd0) fsm_q <= StFinal;
               else cnt_q <= cnt_q - 4'd1;
            end
            StFinal: begin
               P     <= ark;
               valid <= 1'b1;
               busy  <= 1'b0;
               fsm_q <= StIdle;
            end
            default: fsm_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 Parameter: ROUND, 10, number of AES-128 rounds; only 10 is supported.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a decryption; sampled only while busy=0.
REQ-005 Port: C  input  128  ciphertext block, byte 0 in bits [127:120]; captured on the accepting edge.
REQ-006 Port: K  input  128  AES-128 cipher key, same byte order as C; captured on the accepting edge.
REQ-007 Port: P  output  128  recovered plaintext, registered.
REQ-008 Port: valid  output  1  one-cycle pulse; P holds a new result.
REQ-009 Port: busy  output  1  high from the edge after acceptance until the edge that asserts valid.

Function
REQ-010 Iterative datapath, one AES round per clock; FSM states IDLE, KEYEXP, INIT, ROUNDS, FINAL.
REQ-011 IDLE: start=1 at edge E0 latches C and K, loads round key with K, clears round counter, goes to KEYEXP, busy=1.
REQ-012 KEYEXP: edges E1..E10 apply the forward key schedule (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36); after E10 the key register holds round key 10.
REQ-013 INIT (E11): state <= C xor rk10, and key register <= rk9 via the inverse key schedule.
REQ-014 ROUNDS (E12..E20, rounds 9 down to 1): state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_r)); key steps r -> r-1 each edge.
REQ-015 FINAL (E21): P <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0); valid <= 1; busy <= 0; next state IDLE.
REQ-016 Latency on a cold start: valid asserts exactly 21 edges after the accepting edge; throughput is one block per 22 cycles.
REQ-017 rk0 produced by the inverse schedule SHALL equal the latched K; no copy of K is used for the final round.
REQ-018 start while busy=1 is ignored; C and K changes while busy=1 have no effect.
REQ-019 start asserted in the same cycle that valid is high is accepted, because busy is already 0.
REQ-020 valid is high for exactly one cycle per accepted start; P holds its value until the next FINAL edge.
REQ-021 InvSubBytes uses a dedicated inverse S-box submodule; the key schedule reuses the existing forward S-box.

Reset
REQ-022 rst=0 asynchronously forces IDLE, P=0, valid=0, busy=0, and clears the state, key and counter registers.
REQ-023 A reset during any non-IDLE state aborts the operation; no valid pulse is produced for that request.
REQ-024 After rst deasserts, the first rising edge may accept start.

Configuration
REQ-025 Macro AES_DEC_KEYCACHE_EN: when defined, the module stores rk10 and the key it was derived from.
REQ-026 With AES_DEC_KEYCACHE_EN defined, a start whose K equals the cached key skips KEYEXP.
REQ-027 On such a cache hit, IDLE goes directly to INIT, loading the key register from the cached rk10, and valid asserts 11 edges after acceptance.
REQ-028 With AES_DEC_KEYCACHE_EN defined, a cache miss behaves per REQ-016 and updates the cache at the end of KEYEXP.
REQ-029 Reset invalidates the cache.
REQ-030 Without AES_DEC_KEYCACHE_EN, no cache storage exists and every start takes 21 cycles.

Verification
REQ-031 Scenario (FIPS-197 C.1): K=000102030405060708090a0b0c0d0e0f, C=69c4e0d86a7b0430d8cdb78070b4c55a -> P=00112233445566778899aabbccddeeff, valid one cycle, 21 edges after start.
REQ-032 Scenario (FIPS-197 App. B): K=2b7e151628aed2a6abf7158809cf4f3c, C=3925841d02dc09fbdc118597196a0b32 -> P=3243f6a8885a308d313198a2e0370734.
REQ-033 Scenario: start pulsed again at edges E5 and E15 of an operation with altered C -> single valid, P unchanged from REQ-031 result.
REQ-034 Scenario: rst=0 asserted at edge E13 -> P=0, valid=0, busy=0 immediately; a subsequent REQ-032 request decrypts correctly.
REQ-035 Scenario: back-to-back starts, second start asserted in the valid cycle -> both correct results, valid pulses 22 cycles apart.
REQ-036 Scenario (AES_DEC_KEYCACHE_EN defined): two requests with the same K -> second valid 11 edges after start; then a different K -> 21 edges; all results correct.
